// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake plus serial line and status signals of uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic             tx_en;
  logic             txd;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output din, din_valid, tx_en,
    input  din_ready, txd, busy, fifo_count
  );

  modport slave (
    input  din, din_valid, tx_en,
    output din_ready, txd, busy, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a bit-timed serialiser.
module uart_tx_fifo #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             txd_q, txd_n;
  logic             busy_q, busy_n;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             din_ready;
  logic             push, pop;
  logic             bit_done, can_start;

  assign din_ready      = (count != CNT_W'(DEPTH));
  assign push           = bus.din_valid && din_ready;
  assign bit_done       = (timer == TMR_W'(DIV - 1));
  assign can_start      = (count != '0) && bus.tx_en;

  assign bus.din_ready  = din_ready;
  assign bus.fifo_count = count;
  assign bus.txd        = txd_q;
  assign bus.busy       = busy_q;

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      txd_q   <= txd_n;
      busy_q  <= busy_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  // txd is registered, so each transition pre-computes the level of the next bit
  always_comb begin
    state_n   = state;
    timer_n   = timer + TMR_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd_q;
    busy_n    = busy_q;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (can_start) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          txd_n     = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            txd_n     = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_n = '0;
          if (can_start) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule
